// File: rtl/bresenham_ray_tracer.sv
// bresenham_ray_tracer: 2D occupancy-grid ray tracer. Emits the hit cell once as occupied,
// then walks origin -> hit emitting each cell as free. Define BRESENHAM_MAX_RANGE_EN to cap free cells at MAX_FREE.
module bresenham_ray_tracer #(
  parameter int COORD_W  = 8,
  parameter int MAX_FREE = 255
) (
  input  logic               clock,
  input  logic               reset,
  input  logic               start,
  input  logic [COORD_W-1:0] x0,
  input  logic [COORD_W-1:0] y0,
  input  logic [COORD_W-1:0] x1,
  input  logic [COORD_W-1:0] y1,
  input  logic               occupancy_busy,
  output logic [COORD_W-1:0] cell_x,
  output logic [COORD_W-1:0] cell_y,
  output logic               cell_is_free,
  output logic               write_enable,
  output logic               busy,
  output logic               done
);
  localparam int ERR_W = COORD_W + 2;

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_SET_UP = 3'd1,
    S_OCC    = 3'd2,
    S_FREE   = 3'd3,
    S_DONE   = 3'd4
  } state_t;

  state_t                  state_q, state_d;
  logic [COORD_W-1:0]      ox_q, ox_d, oy_q, oy_d, hx_q, hx_d, hy_q, hy_d;
  logic [COORD_W-1:0]      cx_q, cx_d, cy_q, cy_d;
  logic signed [ERR_W-1:0] dx_q, dx_d, dy_q, dy_d, err_q, err_d;
  logic                    sx_neg_q, sx_neg_d, sy_neg_q, sy_neg_d;
  logic [COORD_W-1:0]      cell_x_q, cell_x_d, cell_y_q, cell_y_d;
  logic                    cell_is_free_q, cell_is_free_d;
  logic                    write_enable_q, write_enable_d;
  logic                    busy_q, busy_d, done_q, done_d;

  logic                    accept_s, step_x_s, step_y_s, at_hit_s, cap_hit_s;
  logic [COORD_W-1:0]      abs_x_s, abs_y_s, nx_s, ny_s;
  logic signed [ERR_W:0]   e2_s, dx_ext_s, dy_ext_s;
  logic signed [ERR_W-1:0] err_step_s;

  assign accept_s = write_enable_q & ~occupancy_busy;
  assign abs_x_s  = (hx_q >= ox_q) ? (hx_q - ox_q) : (ox_q - hx_q);
  assign abs_y_s  = (hy_q >= oy_q) ? (hy_q - oy_q) : (oy_q - hy_q);

  // One extra bit keeps 2*err exact for the comparisons against dx and dy.
  assign e2_s     = {err_q, 1'b0};
  assign dx_ext_s = {dx_q[ERR_W-1], dx_q};
  assign dy_ext_s = {dy_q[ERR_W-1], dy_q};
  assign step_x_s = (e2_s >= dy_ext_s);
  assign step_y_s = (e2_s <= dx_ext_s);

  assign nx_s = step_x_s ? (sx_neg_q ? (cx_q - COORD_W'(1)) : (cx_q + COORD_W'(1))) : cx_q;
  assign ny_s = step_y_s ? (sy_neg_q ? (cy_q - COORD_W'(1)) : (cy_q + COORD_W'(1))) : cy_q;
  assign err_step_s = err_q + (step_x_s ? dy_q : $signed(ERR_W'(0)))
                            + (step_y_s ? dx_q : $signed(ERR_W'(0)));
  assign at_hit_s = (nx_s == hx_q) && (ny_s == hy_q);

`ifdef BRESENHAM_MAX_RANGE_EN
  localparam int CNT_W = $clog2(MAX_FREE + 1);
  logic [CNT_W-1:0] free_cnt_q, free_cnt_d;

  assign cap_hit_s = ((free_cnt_q + CNT_W'(1)) == CNT_W'(MAX_FREE));

  // Free-cell counter next value: cleared per ray, bumped on each accepted free write.
  always_comb begin
    free_cnt_d = free_cnt_q;
    if (state_q == S_SET_UP) begin
      free_cnt_d = '0;
    end else if ((state_q == S_FREE) && accept_s) begin
      free_cnt_d = free_cnt_q + CNT_W'(1);
    end else begin
      free_cnt_d = free_cnt_q;
    end
  end

  // Free-cell counter register.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      free_cnt_q <= '0;
    end else begin
      free_cnt_q <= free_cnt_d;
    end
  end
`else
  assign cap_hit_s = (MAX_FREE < 0);
`endif

  // Next-state and next-output logic; outputs are registered alongside the state.
  always_comb begin
    state_d        = state_q;
    ox_d           = ox_q;
    oy_d           = oy_q;
    hx_d           = hx_q;
    hy_d           = hy_q;
    cx_d           = cx_q;
    cy_d           = cy_q;
    dx_d           = dx_q;
    dy_d           = dy_q;
    err_d          = err_q;
    sx_neg_d       = sx_neg_q;
    sy_neg_d       = sy_neg_q;
    cell_x_d       = cell_x_q;
    cell_y_d       = cell_y_q;
    cell_is_free_d = cell_is_free_q;
    write_enable_d = write_enable_q;
    done_d         = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (start && !occupancy_busy) begin
          state_d = S_SET_UP;
          ox_d    = x0;
          oy_d    = y0;
          hx_d    = x1;
          hy_d    = y1;
        end else begin
          state_d = S_IDLE;
        end
      end
      S_SET_UP: begin
        dx_d           = $signed({2'b00, abs_x_s});
        dy_d           = -$signed({2'b00, abs_y_s});
        err_d          = $signed({2'b00, abs_x_s}) - $signed({2'b00, abs_y_s});
        sx_neg_d       = (hx_q < ox_q);
        sy_neg_d       = (hy_q < oy_q);
        cx_d           = ox_q;
        cy_d           = oy_q;
        state_d        = S_OCC;
        cell_x_d       = hx_q;
        cell_y_d       = hy_q;
        cell_is_free_d = 1'b0;
        write_enable_d = 1'b1;
      end
      S_OCC: begin
        if (accept_s && (ox_q == hx_q) && (oy_q == hy_q)) begin
          state_d        = S_DONE;
          write_enable_d = 1'b0;
          cell_x_d       = '0;
          cell_y_d       = '0;
          done_d         = 1'b1;
        end else if (accept_s) begin
          state_d        = S_FREE;
          cell_x_d       = cx_q;
          cell_y_d       = cy_q;
          cell_is_free_d = 1'b1;
        end else begin
          state_d = S_OCC;
        end
      end
      S_FREE: begin
        if (accept_s) begin
          cx_d  = nx_s;
          cy_d  = ny_s;
          err_d = err_step_s;
          if (at_hit_s || cap_hit_s) begin
            state_d        = S_DONE;
            write_enable_d = 1'b0;
            cell_is_free_d = 1'b0;
            cell_x_d       = '0;
            cell_y_d       = '0;
            done_d         = 1'b1;
          end else begin
            state_d  = S_FREE;
            cell_x_d = nx_s;
            cell_y_d = ny_s;
          end
        end else begin
          state_d = S_FREE;
        end
      end
      S_DONE: begin
        state_d        = S_IDLE;
        write_enable_d = 1'b0;
        cell_is_free_d = 1'b0;
        cell_x_d       = '0;
        cell_y_d       = '0;
      end
      default: begin
        state_d        = S_IDLE;
        write_enable_d = 1'b0;
        cell_is_free_d = 1'b0;
        cell_x_d       = '0;
        cell_y_d       = '0;
      end
    endcase
    busy_d = (state_d != S_IDLE);
  end

  // State, datapath and output registers.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q        <= S_IDLE;
      ox_q           <= '0;
      oy_q           <= '0;
      hx_q           <= '0;
      hy_q           <= '0;
      cx_q           <= '0;
      cy_q           <= '0;
      dx_q           <= '0;
      dy_q           <= '0;
      err_q          <= '0;
      sx_neg_q       <= 1'b0;
      sy_neg_q       <= 1'b0;
      cell_x_q       <= '0;
      cell_y_q       <= '0;
      cell_is_free_q <= 1'b0;
      write_enable_q <= 1'b0;
      busy_q         <= 1'b0;
      done_q         <= 1'b0;
    end else begin
      state_q        <= state_d;
      ox_q           <= ox_d;
      oy_q           <= oy_d;
      hx_q           <= hx_d;
      hy_q           <= hy_d;
      cx_q           <= cx_d;
      cy_q           <= cy_d;
      dx_q           <= dx_d;
      dy_q           <= dy_d;
      err_q          <= err_d;
      sx_neg_q       <= sx_neg_d;
      sy_neg_q       <= sy_neg_d;
      cell_x_q       <= cell_x_d;
      cell_y_q       <= cell_y_d;
      cell_is_free_q <= cell_is_free_d;
      write_enable_q <= write_enable_d;
      busy_q         <= busy_d;
      done_q         <= done_d;
    end
  end

  assign cell_x       = cell_x_q;
  assign cell_y       = cell_y_q;
  assign cell_is_free = cell_is_free_q;
  assign write_enable = write_enable_q;
  assign busy         = busy_q;
  assign done         = done_q;

endmodule
